// File: rtl/gb_instr_sequencer.sv
// gb_instr_sequencer: buffers host opcodes in a FIFO and issues them to the gbprocessor
// as one-cycle valid strobes spaced GAP+1 cycles apart.
// Ports: clock, reset (async, active-high); in_instruction/in_valid/in_ready host push side;
// instruction/valid registered issue outputs; fifo_count occupancy; busy activity flag.
// Optional GB_SEQ_STATS_EN adds issued_count (wrapping) and drop_count (saturating).
module gb_instr_sequencer #(
   parameter int DEPTH = 8,
   parameter int GAP   = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] in_instruction,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] instruction,
   output logic       valid,
   output logic [4:0] fifo_count,
   output logic       busy
`ifdef GB_SEQ_STATS_EN
   ,
   output logic [15:0] issued_count,
   output logic [7:0]  drop_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] rd_q, wr_q;
   logic [4:0] count_q, count_d;
   logic [3:0] gap_q, gap_d;
   logic [7:0] mem [DEPTH];
   logic [7:0] instr_q, head;
   logic valid_q, push, pop;
   assign in_ready = !reset && (count_q < 5'(DEPTH));
   assign push = in_valid && in_ready;
   assign pop = (state_q == ISSUE) && (count_q != 5'd0);
   // an empty FIFO can only be entering ISSUE because of a same-edge push, so bypass it
   assign head = (count_q == 5'd0) ? in_instruction : mem[rd_q];
   assign count_d = count_q + 5'(push) - 5'(pop);
   always_comb begin
      state_d = state_q;
      gap_d = gap_q;
      case (state_q)
         IDLE: state_d = (count_q != 5'd0) ? ISSUE : IDLE;
         ISSUE: begin
            state_d = WAIT;
            gap_d = 4'(GAP);
         end
         WAIT: begin
            gap_d = gap_q - 4'd1;
            if (gap_q <= 4'd1) state_d = (count_q != 5'd0 || push) ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // outputs are registered from the next state so valid coincides with the ISSUE cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
         gap_q <= '0;
         valid_q <= 1'b0;
         instr_q <= 8'h00;
      end else begin
         state_q <= state_d;
         rd_q <= pop ? rd_q + AW'(1) : rd_q;
         wr_q <= push ? wr_q + AW'(1) : wr_q;
         count_q <= count_d;
         gap_q <= gap_d;
         valid_q <= (state_d == ISSUE);
         instr_q <= (state_d == ISSUE) ? head : 8'h00;
      end
   end
   always_ff @(posedge clock) begin
      if (push) mem[wr_q] <= in_instruction;
   end
   assign instruction = instr_q;
   assign valid = valid_q;
   assign fifo_count = count_q;
   assign busy = (state_q != IDLE) || (count_q != 5'd0);
`ifdef GB_SEQ_STATS_EN
   logic [15:0] issued_q;
   logic [7:0] drop_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         issued_q <= '0;
         drop_q <= '0;
      end else begin
         issued_q <= issued_q + 16'(valid_q);
         drop_q <= (in_valid && !in_ready && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      end
   end
   assign issued_count = issued_q;
   assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_gb_instr_sequencer.sv
// tb_gb_instr_sequencer: scoreboard bench for gb_instr_sequencer.
module tb_gb_instr_sequencer;
   localparam int DEPTH = 8;
   localparam int GAP = 3;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [7:0] in_instruction = 8'h00;
   logic in_valid = 1'b0;
   logic in_ready, valid, busy;
   logic [7:0] instruction;
   logic [4:0] fifo_count;
`ifdef GB_SEQ_STATS_EN
   logic [15:0] issued_count;
   logic [7:0] drop_count;
`endif
   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int stamps[$];

   gb_instr_sequencer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clock(clock), .reset(reset), .in_instruction(in_instruction), .in_valid(in_valid),
      .in_ready(in_ready), .instruction(instruction), .valid(valid),
      .fifo_count(fifo_count), .busy(busy)
`ifdef GB_SEQ_STATS_EN
      , .issued_count(issued_count), .drop_count(drop_count)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // scoreboard: every issue strobe must match the oldest accepted push
   always @(negedge clock) begin
      if (!reset) begin
         total_cnt++;
         if (valid) begin
            stamps.push_back(cyc);
            if (exp_q.size() == 0)
               $display("FAIL issue_unexpected: got instruction %h with empty scoreboard", instruction);
            else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (instruction !== e) $display("FAIL issue_order: got %h want %h", instruction, e);
               else pass_cnt++;
            end
         end else begin
            if (instruction !== 8'h00) $display("FAIL idle_instr: got %h want 00", instruction);
            else pass_cnt++;
         end
      end
   end

   task automatic push(input logic [7:0] x, output bit acc);
      in_valid = 1'b1;
      in_instruction = x;
      acc = in_ready;
      @(posedge clock);
      if (acc) exp_q.push_back(x);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300 && busy; i++) @(negedge clock);
      total_cnt++;
      if (busy !== 1'b0 || exp_q.size() != 0)
         $display("FAIL %s_drain: busy=%b pending=%0d want busy=0 pending=0", name, busy, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_reset;
      #1 reset = 1'b1;
      #2;
      total_cnt++;
      if (valid !== 1'b0 || instruction !== 8'h00 || fifo_count !== 5'd0 || in_ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_state: valid=%b instr=%h count=%0d ready=%b busy=%b want 0/00/0/0/0",
                  valid, instruction, fifo_count, in_ready, busy);
      else pass_cnt++;
      @(negedge clock);
      reset = 1'b0;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_single;
      bit acc;
      push(8'h8C, acc);
      @(negedge clock);
      total_cnt++;
      if (valid !== 1'b0 || fifo_count !== 5'd1) $display("FAIL single_k: valid=%b count=%0d want 0/1", valid, fifo_count);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (valid !== 1'b1 || instruction !== 8'h8C)
         $display("FAIL single_issue: valid=%b instr=%h want 1/8c", valid, instruction);
      else pass_cnt++;
      for (int i = 0; i < GAP; i++) begin
         @(negedge clock);
         total_cnt++;
         if (valid !== 1'b0 || fifo_count !== 5'd0 || busy !== 1'b1)
            $display("FAIL single_wait%0d: valid=%b count=%0d busy=%b want 0/0/1", i, valid, fifo_count, busy);
         else pass_cnt++;
      end
      @(negedge clock);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      bit acc;
      stamps.delete();
      push(8'h80, acc);
      push(8'h81, acc);
      push(8'h82, acc);
      wait_idle("b2b");
      total_cnt++;
      if (stamps.size() != 3) $display("FAIL b2b_pulses: got %0d want 3", stamps.size());
      else begin
         pass_cnt++;
         total_cnt++;
         if (stamps[1] - stamps[0] != GAP + 1 || stamps[2] - stamps[1] != GAP + 1)
            $display("FAIL b2b_spacing: got %0d,%0d want %0d", stamps[1] - stamps[0], stamps[2] - stamps[1], GAP + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_full;
      bit acc, got, pv;
      int n = 0;
      for (int i = 0; i < 80 && fifo_count != 5'(DEPTH); i++) begin
         push(8'h20 + 8'(n), acc);
         if (acc) n++;
      end
      total_cnt++;
      if (fifo_count !== 5'(DEPTH) || in_ready !== 1'b0)
         $display("FAIL full_state: count=%0d ready=%b want %0d/0", fifo_count, in_ready, DEPTH);
      else pass_cnt++;
      in_valid = 1'b1;
      in_instruction = 8'hB7;
      got = 1'b0;
      pv = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         pv = valid;
      end
      total_cnt++;
      if (!got || !pv) $display("FAIL full_unblock: ready_seen=%b prev_valid=%b want 1/1", got, pv);
      else pass_cnt++;
      @(posedge clock);
      if (got) exp_q.push_back(8'hB7);
      #1 in_valid = 1'b0;
      total_cnt++;
      if (fifo_count !== 5'(DEPTH)) $display("FAIL full_refill: count=%0d want %0d", fifo_count, DEPTH);
      else pass_cnt++;
      wait_idle("full");
   endtask

   task automatic test_simultaneous;
      bit acc, hit;
      for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), acc);
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (valid && fifo_count == 5'd3) begin
            hit = 1'b1;
            break;
         end
      end
      push(8'h55, acc);
      total_cnt++;
      if (!hit || fifo_count !== 5'd3) $display("FAIL simul_count: found=%b count=%0d want 1/3", hit, fifo_count);
      else pass_cnt++;
      wait_idle("simul");
   endtask

   task automatic test_reset_mid;
      bit acc, hit;
      for (int i = 0; i < 7; i++) push(8'h60 + 8'(i), acc);
      hit = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (!valid && fifo_count == 5'd5) begin
            hit = 1'b1;
            break;
         end
      end
      total_cnt++;
      if (!hit || busy !== 1'b1) $display("FAIL rmid_setup: found=%b busy=%b want 1/1", hit, busy);
      else pass_cnt++;
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      total_cnt++;
      if (valid !== 1'b0 || instruction !== 8'h00 || fifo_count !== 5'd0 || in_ready !== 1'b0)
         $display("FAIL rmid_async: valid=%b instr=%h count=%0d ready=%b want 0/00/0/0",
                  valid, instruction, fifo_count, in_ready);
      else pass_cnt++;
      @(negedge clock);
      reset = 1'b0;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", in_ready);
      else pass_cnt++;
      stamps.delete();
      repeat (20) @(negedge clock);
      total_cnt++;
      if (stamps.size() != 0 || busy !== 1'b0 || fifo_count !== 5'd0)
         $display("FAIL rmid_stale: pulses=%0d busy=%b count=%0d want 0/0/0", stamps.size(), busy, fifo_count);
      else pass_cnt++;
   endtask

`ifdef GB_SEQ_STATS_EN
   task automatic test_stats;
      bit acc;
      int n = 0;
      int d = 0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 80 && fifo_count != 5'(DEPTH); i++) begin
         push(8'hA0 + 8'(n), acc);
         if (acc) n++;
      end
      for (int i = 0; i < 40 && d < 3; i++) begin
         @(negedge clock);
         if (!in_ready) begin
            in_valid = 1'b1;
            @(posedge clock);
            d++;
            #1 in_valid = 1'b0;
         end
      end
      wait_idle("stats_fill");
      while (n < 10) begin
         push(8'hC0 + 8'(n), acc);
         if (acc) n++;
         wait_idle("stats_top");
      end
      @(negedge clock);
      total_cnt++;
      if (issued_count !== 16'(n) || drop_count !== 8'd3)
         $display("FAIL stats: issued=%0d drop=%0d want %0d/3", issued_count, drop_count, n);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_simultaneous();
      test_reset_mid();
`ifdef GB_SEQ_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
